// File: rtl/zif_tx_framer.sv
// zif_tx_framer
// Framing stage in front of the ZIF TX AXI-stream port. Unframed 32-bit
// samples are buffered in a small FIFO and re-emitted as fixed-length frames
// with tkeep/tlast. An upstream tlast closes a frame early.
// Optional feature macro: ZIF_TX_FRAMER_HDR_EN. When defined, every frame is
// prefixed by a header word {seq[15:0], len[15:0]}. When undefined, the header
// state and the sequence register are not built.

module zif_tx_framer #(
    parameter int          FIFO_AW   = 4,
    parameter logic [15:0] HDR_MAGIC = 16'hA5C3
) (
    input  logic        axis_zif_clk_in,
    input  logic        reset0_in,
    input  logic        enable_in,
    input  logic [15:0] frame_len_in,
    input  logic [31:0] s_axis_tdata_in,
    input  logic        s_axis_tvalid_in,
    input  logic        s_axis_tlast_in,
    output logic        s_axis_tready_out,
    output logic [31:0] m_axis_tdata_out,
    output logic [3:0]  m_axis_tkeep_out,
    output logic        m_axis_tlast_out,
    output logic        m_axis_tvalid_out,
    input  logic        m_axis_tready_in,
    output logic [15:0] frame_cnt_out,
    output logic [15:0] early_cnt_out,
    output logic        busy_out
);

    localparam int DEPTH = 1 << FIFO_AW;

    // The magic value is reserved for a future header format; zero is not allowed.
    if (HDR_MAGIC == 16'h0000) begin : g_magic_reserved
        $error("zif_tx_framer: HDR_MAGIC must be non-zero");
    end

`ifdef ZIF_TX_FRAMER_HDR_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2
    } state_t;
`else
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PAY  = 1'b1
    } state_t;
`endif

    state_t state_q;
    state_t state_nxt;

    // FIFO storage and bookkeeping
    logic [32:0]        fifo_mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW:0]   fifo_count_q;
    logic [FIFO_AW:0]   fifo_count_nxt;
    logic               in_ready_q;
    logic               fifo_empty;
    logic               fifo_wr;
    logic               fifo_rd;
    logic [32:0]        fifo_head;
    logic [31:0]        head_data;
    logic               head_last;

    // Frame bookkeeping
    logic [15:0] len_q;
    logic [15:0] cnt_q;
    logic [15:0] len_eff;
    logic [15:0] len_sel;
    logic [15:0] load_idx;
    logic        pay_last;
    logic        pay_early;
`ifdef ZIF_TX_FRAMER_HDR_EN
    logic [15:0] seq_q;
`endif

    // Output register
    logic        m_valid_q;
    logic [31:0] m_data_q;
    logic        m_last_q;
    logic        m_early_q;
    logic        out_fire;

    // Control strobes from the FSM output decode
    logic load_hdr;
    logic load_pay;
    logic drop_valid;
    logic close_frame;
    logic len_load;
    logic cnt_clr;
    logic cnt_inc;

    logic [15:0] frame_cnt_q;
    logic [15:0] early_cnt_q;

    assign fifo_empty = (fifo_count_q == '0);
    assign fifo_wr    = s_axis_tvalid_in && in_ready_q;
    assign fifo_head  = fifo_mem[rd_ptr_q];
    assign head_data  = fifo_head[31:0];
    assign head_last  = fifo_head[32];
    assign out_fire   = m_valid_q && m_axis_tready_in;
    assign len_eff    = (frame_len_in == 16'd0) ? 16'd1 : frame_len_in;
    assign pay_last   = (load_idx == (len_sel - 16'd1)) || head_last;
    assign pay_early  = head_last && (load_idx < (len_sel - 16'd1));

    assign fifo_count_nxt = fifo_count_q
                          + {{FIFO_AW{1'b0}}, fifo_wr}
                          - {{FIFO_AW{1'b0}}, fifo_rd};

    // FIFO storage has no reset; only entries below the count are ever read.
    always_ff @(posedge axis_zif_clk_in) begin
        if (fifo_wr) begin
            fifo_mem[wr_ptr_q] <= {s_axis_tlast_in, s_axis_tdata_in};
        end
    end

    // FIFO pointers, occupancy and the registered ready (not-full) flag.
    always_ff @(posedge axis_zif_clk_in) begin
        if (reset0_in) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
            in_ready_q   <= 1'b0;
        end else begin
            if (fifo_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (fifo_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            fifo_count_q <= fifo_count_nxt;
            in_ready_q   <= (fifo_count_nxt != (FIFO_AW + 1)'(DEPTH));
        end
    end

    // FSM state register.
    always_ff @(posedge axis_zif_clk_in) begin
        if (reset0_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable_in && !fifo_empty) begin
`ifdef ZIF_TX_FRAMER_HDR_EN
                    state_nxt = ST_HDR;
`else
                    state_nxt = ST_PAY;
`endif
                end
            end
`ifdef ZIF_TX_FRAMER_HDR_EN
            ST_HDR: begin
                if (out_fire) begin
                    state_nxt = ST_PAY;
                end
            end
`endif
            ST_PAY: begin
                if (out_fire && m_last_q) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM output decode: which word (if any) enters the output register this cycle.
    always_comb begin
        load_hdr    = 1'b0;
        load_pay    = 1'b0;
        drop_valid  = 1'b0;
        close_frame = 1'b0;
        len_load    = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        fifo_rd     = 1'b0;
        len_sel     = len_q;
        load_idx    = cnt_q + {15'd0, out_fire};
        case (state_q)
            ST_IDLE: begin
                len_sel  = len_eff;
                load_idx = 16'd0;
                if (enable_in && !fifo_empty) begin
                    len_load = 1'b1;
                    cnt_clr  = 1'b1;
`ifdef ZIF_TX_FRAMER_HDR_EN
                    load_hdr = 1'b1;
`else
                    load_pay = 1'b1;
                    fifo_rd  = 1'b1;
`endif
                end
            end
`ifdef ZIF_TX_FRAMER_HDR_EN
            ST_HDR: begin
                load_idx = 16'd0;
                if (out_fire) begin
                    if (!fifo_empty) begin
                        load_pay = 1'b1;
                        fifo_rd  = 1'b1;
                    end else begin
                        drop_valid = 1'b1;
                    end
                end
            end
`endif
            ST_PAY: begin
                if (out_fire && m_last_q) begin
                    close_frame = 1'b1;
                    drop_valid  = 1'b1;
                end else begin
                    cnt_inc = out_fire;
                    if ((!m_valid_q || out_fire) && !fifo_empty) begin
                        load_pay = 1'b1;
                        fifo_rd  = 1'b1;
                    end else if (out_fire) begin
                        drop_valid = 1'b1;
                    end
                end
            end
            default: begin
                drop_valid = 1'b0;
            end
        endcase
    end

    // Output register; holds its contents until the downstream handshake.
    always_ff @(posedge axis_zif_clk_in) begin
        if (reset0_in) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            m_early_q <= 1'b0;
        end else if (load_hdr) begin
            m_valid_q <= 1'b1;
`ifdef ZIF_TX_FRAMER_HDR_EN
            m_data_q  <= {seq_q, len_eff};
`else
            m_data_q  <= {16'd0, len_eff};
`endif
            m_last_q  <= 1'b0;
            m_early_q <= 1'b0;
        end else if (load_pay) begin
            m_valid_q <= 1'b1;
            m_data_q  <= head_data;
            m_last_q  <= pay_last;
            m_early_q <= pay_early;
        end else if (drop_valid) begin
            m_valid_q <= 1'b0;
        end
    end

    // Frame length latch and payload word counter.
    always_ff @(posedge axis_zif_clk_in) begin
        if (reset0_in) begin
            len_q <= 16'd1;
            cnt_q <= '0;
        end else begin
            if (len_load) begin
                len_q <= len_eff;
            end
            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (cnt_inc) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

`ifdef ZIF_TX_FRAMER_HDR_EN
    // Header sequence number advances once per completed frame.
    always_ff @(posedge axis_zif_clk_in) begin
        if (reset0_in) begin
            seq_q <= '0;
        end else if (close_frame) begin
            seq_q <= seq_q + 16'd1;
        end
    end
`endif

    // Status counters for completed and early-closed frames; both wrap.
    always_ff @(posedge axis_zif_clk_in) begin
        if (reset0_in) begin
            frame_cnt_q <= '0;
            early_cnt_q <= '0;
        end else if (close_frame) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
            if (m_early_q) begin
                early_cnt_q <= early_cnt_q + 16'd1;
            end
        end
    end

    assign s_axis_tready_out = in_ready_q;
    assign m_axis_tdata_out  = m_data_q;
    assign m_axis_tkeep_out  = {4{m_valid_q}};
    assign m_axis_tlast_out  = m_last_q;
    assign m_axis_tvalid_out = m_valid_q;
    assign frame_cnt_out     = frame_cnt_q;
    assign early_cnt_out     = early_cnt_q;
    assign busy_out          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_zif_tx_framer.sv
// tb_zif_tx_framer
// Randomised bench for zif_tx_framer. Accepted input words go into a queue;
// a frame-level reference model turns them into the expected beat stream
// (optional header, payload, tlast rule) and the expected status counters.

module tb_zif_tx_framer;

    logic        clk = 1'b0;
    logic        reset0 = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] frame_len = 16'd1;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_last;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [15:0] frame_cnt;
    logic [15:0] early_cnt;
    logic        busy;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } word_t;

    word_t       scb_q[$];
    int          check_cnt = 0;
    int          fail_cnt = 0;
    int          accepted_cnt = 0;
    int          ready_mode = 1;

    // reference model state
    bit          mdl_in_frame = 1'b0;
    int          mdl_idx = 0;
    int          mdl_len = 1;
    logic [15:0] mdl_seq = '0;
    int          mdl_frames = 0;
    int          mdl_early = 0;

    // monitor bookkeeping
    bit          gap_pending = 1'b0;
    bit          hold_pending = 1'b0;
    logic [31:0] hold_data = '0;
    logic        hold_last = 1'b0;

    always #5 clk = ~clk;

    zif_tx_framer dut (
        .axis_zif_clk_in   (clk),
        .reset0_in         (reset0),
        .enable_in         (enable),
        .frame_len_in      (frame_len),
        .s_axis_tdata_in   (s_data),
        .s_axis_tvalid_in  (s_valid),
        .s_axis_tlast_in   (s_last),
        .s_axis_tready_out (s_ready),
        .m_axis_tdata_out  (m_data),
        .m_axis_tkeep_out  (m_keep),
        .m_axis_tlast_out  (m_last),
        .m_axis_tvalid_out (m_valid),
        .m_axis_tready_in  (m_ready),
        .frame_cnt_out     (frame_cnt),
        .early_cnt_out     (early_cnt),
        .busy_out          (busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame-level model: a frame is len words, cut short by an upstream tlast.
    task automatic processBeat();
        word_t w;
        bit    exp_last;
        if (!mdl_in_frame) begin
            mdl_in_frame = 1'b1;
            mdl_idx      = 0;
            mdl_len      = (frame_len == 16'd0) ? 1 : int'(frame_len);
`ifdef ZIF_TX_FRAMER_HDR_EN
            checkOutput("hdr_data", m_data, {mdl_seq, 16'(mdl_len)});
            checkOutput("hdr_last", {31'd0, m_last}, 32'd0);
            return;
`endif
        end
        if (scb_q.size() == 0) begin
            checkOutput("spurious_beat", scb_q.size(), 1);
            return;
        end
        w = scb_q.pop_front();
        exp_last = (mdl_idx == mdl_len - 1) || w.last;
        checkOutput("pay_data", m_data, w.data);
        checkOutput("pay_last", {31'd0, m_last}, {31'd0, exp_last});
        if (exp_last) begin
            mdl_frames++;
            if (w.last && (mdl_idx < mdl_len - 1)) begin
                mdl_early++;
            end
            mdl_seq      = mdl_seq + 16'd1;
            mdl_in_frame = 1'b0;
            gap_pending  = 1'b1;
        end
        mdl_idx++;
    endtask

    // Downstream ready generator: 0 = stall, 1 = always ready, else random.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_ready = 1'b0;
                1:       m_ready = 1'b1;
                default: m_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (reset0) begin
            gap_pending  = 1'b0;
            hold_pending = 1'b0;
        end else begin
            if (gap_pending) begin
                checkOutput("frame_gap", {31'd0, m_valid}, 32'd0);
                checkOutput("gap_keep", {28'd0, m_keep}, 32'd0);
                gap_pending = 1'b0;
            end
            if (hold_pending) begin
                checkOutput("hold_valid", {31'd0, m_valid}, 32'd1);
                checkOutput("hold_data", m_data, hold_data);
                checkOutput("hold_last", {31'd0, m_last}, {31'd0, hold_last});
            end
            hold_pending = m_valid && !m_ready;
            hold_data    = m_data;
            hold_last    = m_last;
            if (m_valid && m_ready) begin
                checkOutput("keep", {28'd0, m_keep}, 32'h0000_000F);
                processBeat();
            end
        end
    end

    // Offer n words upstream; the last one always carries tlast.
    task automatic applyStimulus(input int n, input bit rnd, input logic [31:0] base,
                                 input int last_pct, input int gap_pct);
        int    budget;
        bit    acc;
        word_t w;
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b0;
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                @(posedge clk);
                #1;
            end
            s_data  = rnd ? $urandom : base + i;
            s_last  = (i == n - 1) || ($urandom_range(0, 99) < last_pct);
            s_valid = 1'b1;
            acc     = 1'b0;
            budget  = 0;
            while (!acc) begin
                @(negedge clk);
                acc = s_ready && !reset0;
                if (acc) begin
                    w.data = s_data;
                    w.last = s_last;
                    scb_q.push_back(w);
                    accepted_cnt++;
                end
                @(posedge clk);
                #1;
                budget++;
                if (!acc && budget > 3000) begin
                    checkOutput("in_timeout", budget, 0);
                    break;
                end
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic waitIdle();
        int b;
        b = 0;
        while (!(scb_q.size() == 0 && !busy && !m_valid && !mdl_in_frame) && b < 3000) begin
            @(posedge clk);
            #1;
            b++;
        end
        checkOutput("drain_q", scb_q.size(), 0);
        checkOutput("drain_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic checkCounters(input string tag);
        @(negedge clk);
        checkOutput({tag, "_frame_cnt"}, {16'd0, frame_cnt}, {16'd0, 16'(mdl_frames)});
        checkOutput({tag, "_early_cnt"}, {16'd0, early_cnt}, {16'd0, 16'(mdl_early)});
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetState(input string tag, input logic exp_ready);
        checkOutput({tag, "_valid"}, {31'd0, m_valid}, 32'd0);
        checkOutput({tag, "_keep"}, {28'd0, m_keep}, 32'd0);
        checkOutput({tag, "_last"}, {31'd0, m_last}, 32'd0);
        checkOutput({tag, "_data"}, m_data, 32'd0);
        checkOutput({tag, "_frame_cnt"}, {16'd0, frame_cnt}, 32'd0);
        checkOutput({tag, "_early_cnt"}, {16'd0, early_cnt}, 32'd0);
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_s_ready"}, {31'd0, s_ready}, {31'd0, exp_ready});
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int    base_acc;
        int    cap;
        int    b;
        word_t w;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checkResetState("rst", 1'b0);
        @(posedge clk);
        #1;
        reset0 = 1'b0;
        enable = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rdy_after_rst", {31'd0, s_ready}, 32'd1);
        @(posedge clk);
        #1;

        // latency: accepted in cycle 0, tvalid in cycle 2
        frame_len = 16'd1;
        s_data  = 32'h0000_1234;
        s_last  = 1'b1;
        s_valid = 1'b1;
        @(negedge clk);
        checkOutput("lat_rdy", {31'd0, s_ready}, 32'd1);
        if (s_ready) begin
            w.data = s_data;
            w.last = s_last;
            scb_q.push_back(w);
            accepted_cnt++;
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(negedge clk);
        checkOutput("lat_cyc1", {31'd0, m_valid}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("lat_cyc2", {31'd0, m_valid}, 32'd1);
        @(posedge clk);
        #1;
        waitIdle();
        checkCounters("lat");

        // two full frames of length 4 from words 1..8
        frame_len = 16'd4;
        applyStimulus(8, 1'b0, 32'd1, 0, 0);
        waitIdle();
        checkCounters("len4");

        // zero length is treated as one
        frame_len = 16'd0;
        applyStimulus(1, 1'b0, 32'h0000_DEAD, 0, 0);
        waitIdle();
        checkCounters("len0");

        // early close by upstream tlast
        frame_len = 16'd8;
        applyStimulus(3, 1'b0, 32'h0000_0100, 0, 0);
        waitIdle();
        checkCounters("early");

        // enable low in IDLE keeps the framer idle
        enable    = 1'b0;
        frame_len = 16'd3;
        applyStimulus(2, 1'b0, 32'h0000_0180, 0, 0);
        repeat (10) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("en_off_valid", {31'd0, m_valid}, 32'd0);
        checkOutput("en_off_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        enable = 1'b1;
        waitIdle();
        checkCounters("en_off");

        // downstream stall: FIFO plus the held output word fill up
        ready_mode = 0;
        frame_len  = 16'd5;
        repeat (3) @(posedge clk);
        #1;
        base_acc = accepted_cnt;
`ifdef ZIF_TX_FRAMER_HDR_EN
        cap = 16;
`else
        cap = 17;
`endif
        fork
            applyStimulus(20, 1'b0, 32'h0000_0200, 0, 0);
            begin
                repeat (30) @(posedge clk);
                #1;
                @(negedge clk);
                checkOutput("bp_accepted", accepted_cnt - base_acc, cap);
                checkOutput("bp_s_ready", {31'd0, s_ready}, 32'd0);
                ready_mode = 1;
            end
        join
        waitIdle();
        checkCounters("bp");

        // randomised traffic
        for (int k = 0; k < 6; k++) begin
            frame_len  = 16'($urandom_range(0, 6));
            ready_mode = 2;
            applyStimulus($urandom_range(5, 25), 1'b1, 32'd0, 15, 30);
            ready_mode = 1;
            waitIdle();
            checkCounters("rnd");
        end

        // reset in the middle of the payload
        ready_mode = 1;
        frame_len  = 16'd4;
        repeat (3) @(posedge clk);
        #1;
        applyStimulus(4, 1'b0, 32'h0000_0300, 0, 0);
        b = 0;
        while (!(mdl_in_frame && mdl_idx >= 2) && b < 50) begin
            @(posedge clk);
            #1;
            b++;
        end
        checkOutput("midrst_reached", {31'd0, mdl_in_frame}, 32'd1);
        reset0 = 1'b1;
        @(posedge clk);
        #1;
        scb_q.delete();
        mdl_in_frame = 1'b0;
        mdl_idx      = 0;
        mdl_seq      = '0;
        mdl_frames   = 0;
        mdl_early    = 0;
        @(negedge clk);
        checkResetState("midrst", 1'b0);
        @(posedge clk);
        #1;
        reset0 = 1'b0;
        @(posedge clk);
        #1;
        frame_len = 16'd2;
        applyStimulus(2, 1'b0, 32'h0000_0400, 0, 0);
        waitIdle();
        checkCounters("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", check_cnt, fail_cnt);
        $finish;
    end

endmodule
